qch_device_mc: RTL and testbench
================================

Name: qch_device_mc

Overview:
- Multi-channel Q-channel low-power device: NCH independent write/read FIFO channels behind one Q-channel interface.
- Full Q-channel protocol: accept and deny paths, per-channel upstream flush handshake, and qactive with idle hysteresis.
- Sits between the power controller's Q-channel master and NCH producer/consumer pairs; next-generation replacement for the single-channel, accept-only device.

Parameters:
- NCH, 4, number of data channels (1..16)
- DW, 8, payload width per channel
- ASIZE, 6, FIFO address bits per channel; depth = 2**ASIZE
- IDLE_HOLD, 8, cycles qactive_o stays high after last activity (0 = no hysteresis)
- DENY_TIMEOUT, 256, flush timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- if_wakeup_i  in  1  external wakeup request
- wr_valid_i  in  NCH  per-channel write strobe
- wr_payload_i  in  NCH*DW  packed payloads; channel i at [i*DW +: DW]
- wr_ready_o  out  NCH  write accepted this cycle when high with wr_valid_i
- rd_valid_i  in  NCH  per-channel read strobe
- rd_payload_o  out  NCH*DW  packed read data
- rd_empty_o  out  NCH  per-channel FIFO empty
- wr_flush_o  out  NCH  per-channel upstream flush request
- wr_done_i  in  NCH  per-channel upstream flush complete
- qreqn_i  in  1  Q-channel request, asynchronous, active-low
- qacceptn_o  out  1  Q-channel accept, active-low
- qdeny_o  out  1  Q-channel deny
- qactive_o  out  1  device activity indication

Behaviour:
- Reset values: qacceptn_o=1, qdeny_o=0, wr_flush_o=0, rd_empty_o all 1, wr_ready_o all 1, qactive_o = if_wakeup_i, state Q_RUN.
- Reset is async-asserted and takes effect mid-handshake; FIFO contents are discarded.
- qreqn_i passes through a 2-flop synchroniser with reset value 1 (qreqn_s); only qreqn_s is used internally.
- State machine: Q_RUN, Q_REQUEST, Q_STOPPED, Q_EXIT, Q_DENIED, Q_CONTINUE.
  - Q_RUN -> Q_REQUEST when qreqn_s=0.
  - Q_REQUEST -> Q_DENIED when deny_cond; else -> Q_STOPPED when accept_cond. Deny has priority on the same cycle.
  - Q_STOPPED -> Q_EXIT when qreqn_s=1.
  - Q_EXIT -> Q_RUN on the next cycle.
  - Q_DENIED -> Q_CONTINUE when qreqn_s=1.
  - Q_CONTINUE -> Q_RUN on the next cycle.
- Outputs decoded from the registered state:
  - qacceptn_o=0 only in Q_STOPPED.
  - qdeny_o=1 only in Q_DENIED.
- Flush:
  - On entry to Q_REQUEST, every channel's wr_flush_o is set.
  - Channel i clears wr_flush_o and sets flush_done[i] on the first cycle wr_done_i[i]=1.
  - flush_done clears on leaving Q_REQUEST.
  - wr_done_i outside Q_REQUEST is ignored.
- accept_cond = all flush_done & all rd_empty_o & no wr_valid_i & no rd_valid_i & ~if_wakeup_i.
- deny_cond = if_wakeup_i, or any write accepted while in Q_REQUEST.
- FIFO write/read rules:
  - wr_ready_o[i] = ~full[i] & state not in {Q_STOPPED, Q_EXIT}.
  - A write with wr_ready_o low is dropped and has no side effect.
  - Read when empty: rd_payload_o is held, pointers are unchanged.
  - Read data appears in the cycle after rd_valid_i (registered).
  - Simultaneous read and write on a full FIFO: the read completes; the write is refused that cycle.
  - Simultaneous read and write on an empty FIFO: the write completes; the read returns nothing.
- Pointers are ASIZE+1 bits; full/empty decoded by MSB compare; wrap-around at 2**ASIZE.
- qactive_o = if_wakeup_i | act_q.
  - act_q is set on any wr_valid_i, rd_valid_i or non-empty FIFO.
  - act_q holds for IDLE_HOLD cycles after activity stops, using a saturating down-counter reloaded on activity.
- Minimum qreqn_i-fall to qacceptn_o-fall latency: 5 cycles with wr_done_i already high and all FIFOs empty.

Optional Feature:
- Macro QCH_DENY_TIMEOUT_EN.
- Defined: a counter starts on Q_REQUEST entry. If accept_cond has not occurred within DENY_TIMEOUT cycles, deny_cond is forced and the FSM enters Q_DENIED; wr_flush_o deasserts.
- Undefined: Q_REQUEST waits indefinitely for flush completion; DENY_TIMEOUT is unused.

Decomposition:
- Package qch_pkg: qch_state_t enum (six states above), QCH_SYNC_STAGES=2 constant.
- Sub-module qch_sync_fifo (DW, ASIZE): single-clock FIFO with full/empty, instantiated NCH times via generate.
- dff2_sync is reused for qreqn_i.

Test Plan:
- Idle accept: NCH=4, FIFOs empty, wr_done_i=4'hF held; drop qreqn_i -> wr_flush_o=4'hF one cycle, qacceptn_o=0 five cycles after the qreqn_i fall; raise qreqn_i -> qacceptn_o=1 after sync+2 cycles.
- Drain then accept: load 3 bytes into channel 2, request, read all 3 -> qacceptn_o falls only after rd_empty_o[2]=1 and wr_done_i[2] seen.
- Deny on write: in Q_REQUEST, write 8'hA5 to channel 0 -> qdeny_o=1 next cycle, qacceptn_o stays 1; raise qreqn_i -> qdeny_o=0, data 8'hA5 readable.
- Wakeup priority: if_wakeup_i=1 on the same cycle accept_cond holds -> Q_DENIED, not Q_STOPPED; qactive_o=1 the same cycle.
- FIFO boundaries: write 64 bytes to channel 1 -> wr_ready_o[1]=0; 65th write dropped; simultaneous read and write at full -> count 63; pointer wrap verified over 130 entries.
- Timeout (macro on, DENY_TIMEOUT=16): hold wr_done_i=0 -> qdeny_o=1 at 16 cycles after Q_REQUEST entry; async reset mid-Q_STOPPED -> qacceptn_o=1 immediately.

Source files
------------

// File: rtl/qch_pkg.sv
// rtl/qch_pkg.sv - shared Q-channel state encoding and synchroniser depth
package qch_pkg;

  typedef enum logic [2:0] {
    Q_RUN,
    Q_REQUEST,
    Q_STOPPED,
    Q_EXIT,
    Q_DENIED,
    Q_CONTINUE
  } qch_state_t;

  localparam int QCH_SYNC_STAGES = 2;

endpackage

// File: rtl/dff2_sync.sv
// rtl/dff2_sync.sv - two-flop synchroniser for a single asynchronous level
module dff2_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qch_sync_fifo.sv
// rtl/qch_sync_fifo.sv - single-clock FIFO, registered read data, extra-MSB pointers
module qch_sync_fifo #(
  parameter int DW    = 8,
  parameter int ASIZE = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DW-1:0] mem [DEPTH];
  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           do_wr;
  logic           do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  // Full refuses the write even when a read frees a slot in the same cycle.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr[ASIZE-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + (ASIZE+1)'(1);
      end
      if (do_rd) begin
        rptr    <= rptr + (ASIZE+1)'(1);
        rd_data <= mem[rptr[ASIZE-1:0]];
      end
    end
  end

endmodule

// File: rtl/qch_device_mc.sv
// rtl/qch_device_mc.sv - multi-channel Q-channel device; QCH_DENY_TIMEOUT_EN adds a flush timeout deny
module qch_device_mc
  import qch_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int DW           = 8,
  parameter int ASIZE        = 6,
  parameter int IDLE_HOLD    = 8,
  parameter int DENY_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_wakeup_i,
  input  logic [NCH-1:0]    wr_valid_i,
  input  logic [NCH*DW-1:0] wr_payload_i,
  output logic [NCH-1:0]    wr_ready_o,
  input  logic [NCH-1:0]    rd_valid_i,
  output logic [NCH*DW-1:0] rd_payload_o,
  output logic [NCH-1:0]    rd_empty_o,
  output logic [NCH-1:0]    wr_flush_o,
  input  logic [NCH-1:0]    wr_done_i,
  input  logic              qreqn_i,
  output logic              qacceptn_o,
  output logic              qdeny_o,
  output logic              qactive_o
);

  localparam int CW = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;

  qch_state_t     state_q;
  qch_state_t     state_d;
  logic           qreqn_s;
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] wr_acc;
  logic [NCH-1:0] flush_q;
  logic [NCH-1:0] flush_done_q;
  logic           wr_open;
  logic           accept_cond;
  logic           deny_cond;
  logic           timeout;
  logic           activity;
  logic           act_q;
  logic [CW-1:0]  hold_cnt;

  dff2_sync #(.RST_VAL(1'b1)) u_qreqn_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (qreqn_i),
    .q     (qreqn_s)
  );

  assign wr_open    = !(state_q inside {Q_STOPPED, Q_EXIT});
  assign wr_ready_o = ~full & {NCH{wr_open}};
  assign wr_acc     = wr_valid_i & wr_ready_o;
  assign rd_empty_o = empty;
  assign wr_flush_o = flush_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    qch_sync_fifo #(.DW(DW), .ASIZE(ASIZE)) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .wr_en   (wr_acc[g]),
      .wr_data (wr_payload_i[g*DW +: DW]),
      .rd_en   (rd_valid_i[g]),
      .rd_data (rd_payload_o[g*DW +: DW]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

`ifdef QCH_DENY_TIMEOUT_EN
  localparam int TW = $clog2(DENY_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent in Q_REQUEST; restarts on every fresh request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state_q != Q_REQUEST) begin
      tmo_cnt <= '0;
    end else if (!timeout) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout = (state_q == Q_REQUEST) && (tmo_cnt >= TW'(DENY_TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = |DENY_TIMEOUT;
  assign timeout    = 1'b0;
`endif

  assign accept_cond = (&flush_done_q) & (&empty) & ~(|wr_valid_i) & ~(|rd_valid_i) & ~if_wakeup_i;
  assign deny_cond   = if_wakeup_i | (|wr_acc) | timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Q_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qacceptn_o = 1'b1;
    qdeny_o    = 1'b0;
    case (state_q)
      Q_RUN:      if (!qreqn_s) state_d = Q_REQUEST;
      Q_REQUEST: begin
        if (deny_cond)        state_d = Q_DENIED;
        else if (accept_cond) state_d = Q_STOPPED;
      end
      Q_STOPPED: begin
        qacceptn_o = 1'b0;
        if (qreqn_s) state_d = Q_EXIT;
      end
      Q_EXIT:     state_d = Q_RUN;
      Q_DENIED: begin
        qdeny_o = 1'b1;
        if (qreqn_s) state_d = Q_CONTINUE;
      end
      Q_CONTINUE: state_d = Q_RUN;
      default:    state_d = Q_RUN;
    endcase
  end

  // Flush requests live only inside Q_REQUEST; wr_done_i elsewhere is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_q      <= '0;
      flush_done_q <= '0;
    end else if (state_q != Q_REQUEST) begin
      flush_q      <= (state_d == Q_REQUEST) ? '1 : '0;
      flush_done_q <= '0;
    end else if (state_d != Q_REQUEST) begin
      flush_q      <= '0;
      flush_done_q <= '0;
    end else begin
      flush_q      <= flush_q & ~wr_done_i;
      flush_done_q <= flush_done_q | wr_done_i;
    end
  end

  assign activity = (|wr_valid_i) | (|rd_valid_i) | ~(&empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q    <= 1'b0;
      hold_cnt <= '0;
    end else if (activity) begin
      act_q    <= 1'b1;
      hold_cnt <= CW'(IDLE_HOLD);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CW'(1);
    end else begin
      act_q <= 1'b0;
    end
  end

  assign qactive_o = if_wakeup_i | act_q;

endmodule

// File: tb/tb_qch_device_mc.sv
// tb/tb_qch_device_mc.sv - directed Q-channel steps plus randomized FIFO traffic against a queue model
module tb_qch_device_mc;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_wakeup_i;
  logic [3:0]    wr_valid_i;
  logic [31:0]   wr_payload_i;
  logic [3:0]    wr_ready_o;
  logic [3:0]    rd_valid_i;
  logic [31:0]   rd_payload_o;
  logic [3:0]    rd_empty_o;
  logic [3:0]    wr_flush_o;
  logic [3:0]    wr_done_i;
  logic          qreqn_i;
  logic          qacceptn_o;
  logic          qdeny_o;
  logic          qactive_o;

  int passed = 0;
  int total  = 0;

  logic [7:0] mq [NCH][$];
  logic [7:0] last_rd [NCH];

  qch_device_mc #(
    .NCH(NCH), .DW(DW), .ASIZE(6), .IDLE_HOLD(8), .DENY_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_wakeup_i  (if_wakeup_i),
    .wr_valid_i   (wr_valid_i),
    .wr_payload_i (wr_payload_i),
    .wr_ready_o   (wr_ready_o),
    .rd_valid_i   (rd_valid_i),
    .rd_payload_o (rd_payload_o),
    .rd_empty_o   (rd_empty_o),
    .wr_flush_o   (wr_flush_o),
    .wr_done_i    (wr_done_i),
    .qreqn_i      (qreqn_i),
    .qacceptn_o   (qacceptn_o),
    .qdeny_o      (qdeny_o),
    .qactive_o    (qactive_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      last_rd[c] = 8'h00;
    end
  endtask

  // One clock: the queue model applies the FIFO rules to the pre-edge occupancy.
  task automatic cycle();
    int sz [NCH];
    for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (rd_valid_i[c] && sz[c] > 0) last_rd[c] = mq[c].pop_front();
      if (wr_valid_i[c] && sz[c] < DEPTH) mq[c].push_back(wr_payload_i[c*8 +: 8]);
    end
    #1;
    for (int c = 0; c < NCH; c++)
      chk($sformatf("rd_payload%0d", c), 32'(rd_payload_o[c*8 +: 8]), 32'(last_rd[c]));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic flags();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("rd_empty%0d", c), 32'(rd_empty_o[c]), 32'(mq[c].size() == 0));
      chk($sformatf("wr_ready%0d", c), 32'(wr_ready_o[c]), 32'(mq[c].size() < DEPTH));
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    if_wakeup_i  = 1'b0;
    wr_valid_i   = '0;
    wr_payload_i = '0;
    rd_valid_i   = '0;
    wr_done_i    = '0;
    qreqn_i      = 1'b1;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_qacceptn", 32'(qacceptn_o), 32'd1);
    chk("rst_qdeny",    32'(qdeny_o),    32'd0);
    chk("rst_flush",    32'(wr_flush_o), 32'h0);
    chk("rst_empty",    32'(rd_empty_o), 32'hF);
    chk("rst_ready",    32'(wr_ready_o), 32'hF);
    chk("rst_qactive",  32'(qactive_o),  32'd0);
    if_wakeup_i = 1'b1; #1;
    chk("rst_qactive_wake", 32'(qactive_o), 32'd1);
    if_wakeup_i = 1'b0;
    reset_n = 1'b1;
    cycle();

    // Idle accept
    wr_done_i = 4'hF;
    qreqn_i   = 1'b0;
    cycles(3);
    chk("idle_flush_set", 32'(wr_flush_o), 32'hF);
    chk("idle_acc_c3",    32'(qacceptn_o), 32'd1);
    cycle();
    chk("idle_flush_clr", 32'(wr_flush_o), 32'h0);
    chk("idle_acc_c4",    32'(qacceptn_o), 32'd1);
    cycle();
    chk("idle_acc_c5",    32'(qacceptn_o), 32'd0);
    chk("stopped_ready",  32'(wr_ready_o), 32'h0);
    qreqn_i = 1'b1;
    cycles(2);
    chk("exit_acc_c2", 32'(qacceptn_o), 32'd0);
    cycles(2);
    chk("exit_acc_c4", 32'(qacceptn_o), 32'd1);
    chk("exit_ready",  32'(wr_ready_o), 32'hF);

    // Drain then accept on channel 2
    wr_valid_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wr_payload_i = $urandom();
      cycle();
    end
    wr_valid_i = '0;
    qreqn_i = 1'b0;
    cycles(6);
    chk("drain_hold_acc",  32'(qacceptn_o), 32'd1);
    chk("drain_hold_deny", 32'(qdeny_o),    32'd0);
    rd_valid_i = 4'b0100;
    cycles(3);
    rd_valid_i = '0;
    chk("drain_empty2", 32'(rd_empty_o[2]), 32'd1);
    chk("drain_acc_rd", 32'(qacceptn_o),    32'd1);
    cycle();
    chk("drain_accept", 32'(qacceptn_o),    32'd0);
    qreqn_i = 1'b1;
    cycles(4);

    // Deny on write
    wr_done_i = 4'h0;
    qreqn_i   = 1'b0;
    cycles(3);
    wr_valid_i   = 4'b0001;
    wr_payload_i = 32'h0000_00A5;
    cycle();
    wr_valid_i = '0;
    chk("deny_qdeny", 32'(qdeny_o),    32'd1);
    chk("deny_acc",   32'(qacceptn_o), 32'd1);
    qreqn_i = 1'b1;
    cycles(2);
    chk("deny_hold", 32'(qdeny_o), 32'd1);
    cycle();
    chk("deny_clear", 32'(qdeny_o), 32'd0);
    cycle();
    rd_valid_i = 4'b0001;
    cycle();
    rd_valid_i = '0;
    chk("deny_data", 32'(rd_payload_o[7:0]), 32'h0000_00A5);

    // Wakeup wins over a simultaneous accept
    wr_done_i = 4'hF;
    qreqn_i   = 1'b0;
    cycles(4);
    if_wakeup_i = 1'b1; #1;
    chk("wake_qactive", 32'(qactive_o), 32'd1);
    cycle();
    chk("wake_deny", 32'(qdeny_o),    32'd1);
    chk("wake_acc",  32'(qacceptn_o), 32'd1);
    if_wakeup_i = 1'b0;
    qreqn_i = 1'b1;
    cycles(4);
    chk("wake_exit", 32'(qdeny_o), 32'd0);

    // Activity hysteresis
    cycles(12);
    chk("idle_qactive", 32'(qactive_o), 32'd0);
    wr_valid_i = 4'b1000; wr_payload_i = $urandom();
    cycle();
    wr_valid_i = '0; rd_valid_i = 4'b1000;
    cycle();
    rd_valid_i = '0;
    cycles(8);
    chk("hold_qactive", 32'(qactive_o), 32'd1);
    cycles(2);
    chk("hold_expired", 32'(qactive_o), 32'd0);

    // FIFO boundaries on channel 1
    wr_valid_i = 4'b0010;
    for (int i = 0; i < DEPTH; i++) begin
      wr_payload_i = $urandom();
      cycle();
    end
    chk("full_ready1", 32'(wr_ready_o[1]), 32'd0);
    chk("full_empty1", 32'(rd_empty_o[1]), 32'd0);
    wr_payload_i = $urandom();
    cycle();
    chk("drop_ready1", 32'(wr_ready_o[1]), 32'd0);
    rd_valid_i = 4'b0010;
    wr_payload_i = $urandom();
    cycle();
    rd_valid_i = '0;
    chk("rdwr_full_ready1", 32'(wr_ready_o[1]), 32'd1);
    wr_payload_i = $urandom();
    cycle();
    wr_valid_i = '0;
    chk("refill_ready1", 32'(wr_ready_o[1]), 32'd0);

    // Randomized traffic with wrap-around
    for (int n = 0; n < 400; n++) begin
      wr_valid_i = '0;
      rd_valid_i = '0;
      wr_valid_i[1] = 1'($urandom_range(0, 1));
      wr_valid_i[3] = 1'($urandom_range(0, 1));
      rd_valid_i[1] = 1'($urandom_range(0, 1));
      rd_valid_i[3] = 1'($urandom_range(0, 1));
      if (n % 50 == 7) rd_valid_i[0] = 1'b1;
      wr_payload_i = $urandom();
      cycle();
      flags();
    end
    wr_valid_i = '0;
    rd_valid_i = 4'hF;
    cycles(70);
    rd_valid_i = '0;
    flags();

    // Flush timeout or indefinite wait, then async reset in Q_STOPPED
    wr_done_i = 4'h0;
    qreqn_i   = 1'b0;
    cycles(3);
`ifdef QCH_DENY_TIMEOUT_EN
    cycles(15);
    chk("tmo_before",       32'(qdeny_o),    32'd0);
    chk("tmo_flush_before", 32'(wr_flush_o), 32'hF);
    cycle();
    chk("tmo_deny",         32'(qdeny_o),    32'd1);
    chk("tmo_flush_after",  32'(wr_flush_o), 32'h0);
    qreqn_i = 1'b1;
    cycles(4);
    wr_done_i = 4'hF;
    qreqn_i   = 1'b0;
    cycles(5);
`else
    cycles(40);
    chk("wait_deny",  32'(qdeny_o),    32'd0);
    chk("wait_acc",   32'(qacceptn_o), 32'd1);
    chk("wait_flush", 32'(wr_flush_o), 32'hF);
    wr_done_i = 4'hF;
    cycles(2);
`endif
    chk("pre_reset_acc", 32'(qacceptn_o), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("async_rst_acc",   32'(qacceptn_o), 32'd1);
    chk("async_rst_ready", 32'(wr_ready_o), 32'hF);
    chk("async_rst_flush", 32'(wr_flush_o), 32'h0);
    qreqn_i = 1'b1;
    cycle();
    reset_n = 1'b1;
    cycles(2);
    chk("post_rst_acc", 32'(qacceptn_o), 32'd1);
    flags();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
